// File: rtl/memlog_capture_if.sv
// Capture/readback bus of the trigger-capture log memory.
// The observed datapath and the readback master drive the i_* side.
// The capture block drives the o_* side.
interface memlog_capture_if #(
  parameter int DATA_W = 16,
  parameter int NCH    = 2,
  parameter int DEPTH  = 1024
);
  localparam int W  = NCH * DATA_W;
  localparam int AW = $clog2(DEPTH);

  logic          i_run;
  logic          i_mode;
  logic [AW-1:0] i_pretrig;
  logic          i_valid;
  logic          i_trig;
  logic [W-1:0]  i_data;
  logic          o_busy;
  logic          o_done;
  logic [AW-1:0] o_start_addr;
  logic          i_rd_en;
  logic [AW-1:0] i_rd_addr;
  logic [W-1:0]  o_rd_data;
  logic          o_rd_valid;

  modport master (
    output i_run, i_mode, i_pretrig, i_valid, i_trig, i_data, i_rd_en, i_rd_addr,
    input  o_busy, o_done, o_start_addr, o_rd_data, o_rd_valid
  );

  modport slave (
    input  i_run, i_mode, i_pretrig, i_valid, i_trig, i_data, i_rd_en, i_rd_addr,
    output o_busy, o_done, o_start_addr, o_rd_data, o_rd_valid
  );
endinterface

// File: rtl/memlog_capture.sv
// Multi-channel trigger-capture log memory.
// Samples are stored in a simple-dual-port RAM around a trigger event, in one of two modes:
// one-shot post-trigger capture, or circular capture that keeps pretrig samples before the trigger.
// The frozen record is read by logical index, where index 0 is the oldest sample.
module memlog_capture #(
  parameter int    DATA_W          = 16,
  parameter int    NCH             = 2,
  parameter int    DEPTH           = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input logic             clka,
  input logic             rsta,
  memlog_capture_if.slave bus
);
  localparam int W  = NCH * DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] MAX_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          mode_r, mode_s;
  logic [AW-1:0] pretrig_r, pretrig_s;
  logic [AW-1:0] wr_ptr_r, wr_ptr_s;
  logic [AW-1:0] pre_cnt_r, pre_cnt_s;
  logic [AW-1:0] post_rem_r, post_rem_s;
  logic [AW-1:0] start_addr_r, start_addr_s;
  logic          busy_r, done_r;
  logic          we_s, trig_ok_s;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] rd_phys_s;
  logic [W-1:0]  ram_q_r;
  logic          ram_v_r;
  logic [W-1:0]  rd_data_s;
  logic          rd_valid_s;

  // Next-state logic: arming, trigger acceptance, and the write strobe.
  always_comb begin
    state_s      = state_r;
    mode_s       = mode_r;
    pretrig_s    = pretrig_r;
    wr_ptr_s     = wr_ptr_r;
    pre_cnt_s    = pre_cnt_r;
    post_rem_s   = post_rem_r;
    start_addr_s = start_addr_r;
    we_s         = 1'b0;
    trig_ok_s    = 1'b0;
    if (bus.i_run) begin
      // Re-arm from any state; a trigger in this cycle is deliberately ignored.
      state_s   = ST_ARMED;
      wr_ptr_s  = '0;
      pre_cnt_s = '0;
      mode_s    = bus.i_mode;
      pretrig_s = bus.i_pretrig;
    end else begin
      case (state_r)
        ST_ARMED: begin
          if (bus.i_valid) begin
            if (mode_r) begin
              trig_ok_s = bus.i_trig && (pre_cnt_r >= pretrig_r);
            end else begin
              trig_ok_s = bus.i_trig;
            end
            if (trig_ok_s) begin
              we_s     = 1'b1;
              wr_ptr_s = wr_ptr_r + 1'b1;
              if (mode_r) begin
                start_addr_s = wr_ptr_r - pretrig_r;
                post_rem_s   = MAX_IDX - pretrig_r;
              end else begin
                start_addr_s = wr_ptr_r;
                post_rem_s   = MAX_IDX;
              end
              if (post_rem_s == '0) begin
                state_s = ST_DONE;
              end else begin
                state_s = ST_CAPTURE;
              end
            end else if (mode_r) begin
              // The circular pre-trigger history keeps every sample, including early triggers.
              we_s     = 1'b1;
              wr_ptr_s = wr_ptr_r + 1'b1;
              if (pre_cnt_r != MAX_IDX) begin
                pre_cnt_s = pre_cnt_r + 1'b1;
              end else begin
                pre_cnt_s = pre_cnt_r;
              end
            end else begin
              we_s = 1'b0;
            end
          end else begin
            we_s = 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (bus.i_valid) begin
            we_s       = 1'b1;
            wr_ptr_s   = wr_ptr_r + 1'b1;
            post_rem_s = post_rem_r - 1'b1;
            if (post_rem_r == AW'(1)) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_CAPTURE;
            end
          end else begin
            we_s = 1'b0;
          end
        end
        ST_IDLE:  state_s = ST_IDLE;
        ST_DONE:  state_s = ST_DONE;
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // Control registers; the status flags are registered from the next state.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_r      <= ST_IDLE;
      mode_r       <= 1'b0;
      pretrig_r    <= '0;
      wr_ptr_r     <= '0;
      pre_cnt_r    <= '0;
      post_rem_r   <= '0;
      start_addr_r <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      mode_r       <= mode_s;
      pretrig_r    <= pretrig_s;
      wr_ptr_r     <= wr_ptr_s;
      pre_cnt_r    <= pre_cnt_s;
      post_rem_r   <= post_rem_s;
      start_addr_r <= start_addr_s;
      busy_r       <= (state_s == ST_ARMED) || (state_s == ST_CAPTURE);
      done_r       <= (state_s == ST_DONE);
    end
  end

  // RAM write port. Contents are intentionally left untouched by reset.
  always_ff @(posedge clka) begin
    if (we_s) begin
      mem_r[wr_ptr_r] <= bus.i_data;
    end
  end

  // Logical index is rotated by the start address, wrapping modulo DEPTH.
  assign rd_phys_s = start_addr_r + bus.i_rd_addr;

  // RAM read port. The read is read-first against a same-cycle write.
  always_ff @(posedge clka) begin
    if (rsta) begin
      ram_q_r <= '0;
      ram_v_r <= 1'b0;
    end else begin
      ram_v_r <= bus.i_rd_en;
      if (bus.i_rd_en) begin
        ram_q_r <= mem_r[rd_phys_s];
      end
    end
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
    assign rd_data_s  = ram_q_r;
    assign rd_valid_s = ram_v_r;
  end else begin : g_high_perf
    logic [W-1:0] out_q_r;
    logic         out_v_r;

    // Extra output register stage that gives two-cycle read latency.
    always_ff @(posedge clka) begin
      if (rsta) begin
        out_q_r <= '0;
        out_v_r <= 1'b0;
      end else begin
        out_v_r <= ram_v_r;
        if (ram_v_r) begin
          out_q_r <= ram_q_r;
        end
      end
    end

    assign rd_data_s  = out_q_r;
    assign rd_valid_s = out_v_r;
  end

  assign bus.o_busy       = busy_r;
  assign bus.o_done       = done_r;
  assign bus.o_start_addr = start_addr_r;
  assign bus.o_rd_data    = rd_data_s;
  assign bus.o_rd_valid   = rd_valid_s;
endmodule

// File: doc/memlog_capture.md
# memlog_capture

Parametrised multi-channel trigger-capture log memory; successor to the single-channel write-first log RAM. Captures `NCH` packed sample channels into a `DEPTH`-entry simple-dual-port block RAM around a trigger event. Supports one-shot post-trigger capture and circular pre-trigger capture. Sits between the datapath under observation (filter/BER outputs) and the register-file/MicroBlaze readback path, which reads the frozen record by logical index (0 = oldest sample).

## Interface

- `DATA_W`, 16: bits per channel.
- `NCH`, 2: channels captured in parallel; word width `W = NCH*DATA_W`.
- `DEPTH`, 1024: entries; power of two, ≥ 4; `AW = clog2(DEPTH)`.
- `RAM_PERFORMANCE`, "HIGH_PERFORMANCE": "HIGH_PERFORMANCE" gives 2-cycle read latency with output register; "LOW_LATENCY" gives 1-cycle read latency.

- `clka`  in  1  sole clock; all logic is rising-edge.
- `rsta`  in  1  synchronous, active-high reset.
- `i_run`  in  1  single-cycle pulse: arm a new capture and latch `i_mode` and `i_pretrig`.
- `i_mode`  in  1  0 = post-trigger only; 1 = circular with pre-trigger.
- `i_pretrig`  in  AW  pre-trigger sample count; mode 1 only; clamped to `DEPTH-1`.
- `i_valid`  in  1  sample strobe.
- `i_trig`  in  1  trigger qualifier; sampled only when `i_valid`=1.
- `i_data`  in  W  packed samples; channel k at `[k*DATA_W +: DATA_W]`.
- `o_busy`  out  1  high in ARMED or CAPTURE.
- `o_done`  out  1  high in DONE (record frozen).
- `o_start_addr`  out  AW  physical address of logical index 0.
- `i_rd_en`  in  1  read request.
- `i_rd_addr`  in  AW  logical read index.
- `o_rd_data`  out  W  read data.
- `o_rd_valid`  out  1  qualifies `o_rd_data`.

## Operation

- FSM states: IDLE, ARMED, CAPTURE, DONE. Reset state is IDLE.
- In any state, `i_run`=1 causes the following in the next cycle: state becomes ARMED, `wr_ptr`=0, `pre_cnt`=0, `o_done`=0, and mode/pretrig are latched. This aborts any capture in progress. `i_trig` in the same cycle is ignored.
- ARMED, mode 0: samples are not written. The first `i_valid & i_trig` is the trigger.
- ARMED, mode 1: every `i_valid` writes `i_data` to `wr_ptr`, increments `wr_ptr` modulo `DEPTH`, and increments `pre_cnt`, which saturates at `DEPTH-1`. A trigger is accepted only when `pre_cnt >= pretrig`. Triggers arriving earlier are ignored, and that sample is stored as a normal pre-trigger sample.
- Trigger acceptance:
  - The trigger sample is written at `wr_ptr`.
  - `o_start_addr` is loaded with `(wr_ptr - pretrig) mod DEPTH`, or with `wr_ptr` in mode 0.
  - `post_rem` is loaded with `DEPTH - 1 - pretrig`, or `DEPTH-1` in mode 0.
  - The state becomes CAPTURE, or DONE directly if `post_rem`=0.
- The trigger sample always sits at logical index `pretrig` (0 in mode 0).
- CAPTURE: each `i_valid` writes, increments `wr_ptr`, and decrements `post_rem`. The write that takes `post_rem` to 0 moves the state to DONE.
- DONE: no writes. Stays in DONE until `i_run` or `rsta`.
- Read port is independent of the write port (simple dual port) and is legal in every state.
  - Physical address = `(o_start_addr + i_rd_addr) mod DEPTH`.
  - Data is meaningful only in DONE.
  - Reading a location written in the same cycle returns the old contents (read-first).
- `rsta` clears the FSM, pointers, counters, `o_start_addr`, the read pipeline and all outputs. RAM contents are not cleared.

## Timing

- Reset values: `o_busy`=0, `o_done`=0, `o_start_addr`=0, `o_rd_data`=0, `o_rd_valid`=0.
- `o_busy` rises the cycle after `i_run`.
- `o_done` rises the cycle after the final write and stays high until the cycle after `i_run`/`rsta`.
- Read latency, measured from `i_rd_en` at edge N:
  - LOW_LATENCY: `o_rd_valid`=1 with data after edge N+1.
  - HIGH_PERFORMANCE: `o_rd_valid`=1 with data after edge N+2.
- Reads are fully pipelined, one per cycle, with no gaps required.
- A write at edge N is readable by a read issued at edge N+1 or later.
- `rsta` mid-capture: IDLE after that edge; in-flight read results are dropped (`o_rd_valid`=0).

## Test plan

Parameters for all scenarios: DEPTH=16, NCH=2, DATA_W=8, data word = {ch1=0x80+n, ch0=n} for sample n.

- **Mode 0 capture.** Run, then 20 valid samples with trig on n=3 → `o_done` after n=18. Reads of index 0..15 return ch0 = 3..18 (0x03..0x12). `o_start_addr`=0.
- **Mode 1 with pre-trigger.** Mode 1, pretrig=4, continuous valid, trig on n=25 → index 4 holds n=25. Index 0 holds n=21, index 15 holds n=36. `o_start_addr` = (25-4) mod 16 = 5.
- **Early trigger ignored.** Mode 1, pretrig=6, trig on n=2 and n=9 → trigger taken at n=9; index 0 = n=3.
- **Edge cases.**
  - pretrig=15 → DONE the cycle after the trigger write.
  - pretrig=31 → clamped to 15.
  - Gaps in `i_valid` → no extra writes.
- **Restart and reset.**
  - `i_run` with `i_trig` in CAPTURE → re-arm; that trigger is ignored.
  - `rsta` mid-capture → all outputs 0 the next cycle; prior RAM data is still readable after a new DONE.
- **Read latency.** Back-to-back reads 0..15 in both performance modes → `o_rd_valid` at exactly 1 or 2 cycles respectively, data in order.
